// File: rtl/button_event_decoder.sv
// Turns a debounced button level into press/short/long/repeat/release pulses and a press counter.
// One cycle from the sampling edge to each registered output. No backpressure: every pulse lasts one cycle.
module button_event_decoder #(
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 20_000_000,
  parameter int TIMER_W       = 26,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset_count,
  input  logic             db_in,
  input  logic             clr_count,
  output logic             press_tick,
  output logic             short_press,
  output logic             long_press,
  output logic             repeat_tick,
  output logic             release_tick,
  output logic             held,
  output logic [CNT_W-1:0] press_count
);

  typedef enum logic [1:0] {IDLE, PRESSED, LONG} state_t;

  localparam logic [TIMER_W-1:0] LONG_LAST   = TIMER_W'(LONG_CYCLES - 1);
  localparam logic [TIMER_W-1:0] REPEAT_LAST = TIMER_W'(REPEAT_CYCLES - 1);

  state_t             state, state_nxt;
  logic [TIMER_W-1:0] hold_cnt, hold_nxt;
  logic               db_d;
  logic               press_nxt, short_nxt, long_nxt, repeat_nxt, release_nxt;
  logic               cnt_inc;

  always_comb begin
    state_nxt   = state;
    hold_nxt    = hold_cnt;
    press_nxt   = 1'b0;
    short_nxt   = 1'b0;
    long_nxt    = 1'b0;
    repeat_nxt  = 1'b0;
    release_nxt = 1'b0;
    cnt_inc     = 1'b0;
    case (state)
      IDLE: begin
        if (db_in && !db_d) begin
          state_nxt = PRESSED;
          hold_nxt  = '0;
          press_nxt = 1'b1;
        end
      end
      PRESSED: begin
        // Release is tested first so a release on the threshold edge is still a short press.
        if (!db_in) begin
          state_nxt   = IDLE;
          short_nxt   = 1'b1;
          release_nxt = 1'b1;
          cnt_inc     = 1'b1;
        end else if (hold_cnt == LONG_LAST) begin
          state_nxt = LONG;
          long_nxt  = 1'b1;
          hold_nxt  = '0;
          cnt_inc   = 1'b1;
        end else begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      LONG: begin
        if (!db_in) begin
          state_nxt   = IDLE;
          release_nxt = 1'b1;
        end else if (hold_cnt == REPEAT_LAST) begin
          repeat_nxt = 1'b1;
          hold_nxt   = '0;
        end else begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // db_d resets high so a button held through reset needs a fresh rise.
  always_ff @(posedge clk or posedge reset_count) begin
    if (reset_count) begin
      state        <= IDLE;
      hold_cnt     <= '0;
      db_d         <= 1'b1;
      press_tick   <= 1'b0;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      repeat_tick  <= 1'b0;
      release_tick <= 1'b0;
      held         <= 1'b0;
      press_count  <= '0;
    end else begin
      state        <= state_nxt;
      hold_cnt     <= hold_nxt;
      db_d         <= db_in;
      press_tick   <= press_nxt;
      short_press  <= short_nxt;
      long_press   <= long_nxt;
      repeat_tick  <= repeat_nxt;
      release_tick <= release_nxt;
      held         <= (state_nxt != IDLE);
      if (clr_count)
        press_count <= '0;
      else if (cnt_inc)
        press_count <= press_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// Bench for button_event_decoder: fixed vector table, directed corner sequences and random runs vs a press-timeline model.
module tb_button_event_decoder;
  localparam int L  = 8;
  localparam int R  = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset_count;
  logic          db_in;
  logic          clr_count;
  logic          press_tick, short_press, long_press, repeat_tick, release_tick, held;
  logic [CW-1:0] press_count;

  button_event_decoder #(
    .LONG_CYCLES(L), .REPEAT_CYCLES(R), .TIMER_W(8), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset_count(reset_count), .db_in(db_in), .clr_count(clr_count),
    .press_tick(press_tick), .short_press(short_press), .long_press(long_press),
    .repeat_tick(repeat_tick), .release_tick(release_tick), .held(held),
    .press_count(press_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: tracks whether a press is in progress and how many edges have passed since it began.
  bit m_prev, m_in;
  int m_t, m_cnt;
  bit e_press, e_short, e_long, e_rep, e_rel;

  typedef struct {
    bit         db;
    bit         clr;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[10];

  function automatic logic [7:0] dut_vec();
    return {press_tick, short_press, long_press, repeat_tick, release_tick, held, press_count};
  endfunction

  function automatic logic [7:0] model_vec();
    logic [CW-1:0] c;
    c = CW'(m_cnt);
    return {e_press, e_short, e_long, e_rep, e_rel, m_in, c};
  endfunction

  task automatic model_reset();
    m_prev = 1'b1; m_in = 1'b0; m_t = 0; m_cnt = 0;
    e_press = 0; e_short = 0; e_long = 0; e_rep = 0; e_rel = 0;
  endtask

  task automatic model_edge(input bit db, input bit clr);
    int inc;
    inc = 0;
    e_press = 0; e_short = 0; e_long = 0; e_rep = 0; e_rel = 0;
    if (!m_in) begin
      if (db && !m_prev) begin
        m_in = 1; m_t = 0; e_press = 1;
      end
    end else begin
      m_t++;
      if (!db) begin
        m_in = 0; e_rel = 1;
        if (m_t <= L) begin e_short = 1; inc = 1; end
      end else if (m_t == L) begin
        e_long = 1; inc = 1;
      end else if (m_t > L && ((m_t - L) % R) == 0) begin
        e_rep = 1;
      end
    end
    m_cnt  = clr ? 0 : (m_cnt + inc) % (1 << CW);
    m_prev = db;
  endtask

  task automatic check(input string name, input logic [7:0] exp);
    logic [7:0] got;
    got = dut_vec();
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got p/s/l/r/e/h/cnt=%b required %b", name, $time, got, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %b required %b", name, $time, got, exp);
    end
  endtask

  task automatic step(input bit db, input bit clr);
    db_in = db;
    clr_count = clr;
    @(posedge clk);
    #1;
    model_edge(db, clr);
  endtask

  task automatic mstep(input bit db, input bit clr);
    step(db, clr);
    check("model", model_vec());
  endtask

  initial begin
    int long_at, c0, run, lvl;
    int rep_q[$];
    int exp_rep[5] = '{12, 16, 20, 24, 28};
    int exp_wrap[5] = '{1, 2, 3, 0, 1};

    tbl[0] = '{1'b1, 1'b0, 8'b00000000};
    tbl[1] = '{1'b0, 1'b0, 8'b00000000};
    tbl[2] = '{1'b1, 1'b0, 8'b10000100};
    tbl[3] = '{1'b0, 1'b0, 8'b01001001};
    tbl[4] = '{1'b1, 1'b0, 8'b10000101};
    tbl[5] = '{1'b1, 1'b0, 8'b00000101};
    tbl[6] = '{1'b0, 1'b0, 8'b01001010};
    tbl[7] = '{1'b0, 1'b1, 8'b00000000};
    tbl[8] = '{1'b1, 1'b0, 8'b10000100};
    tbl[9] = '{1'b0, 1'b1, 8'b01001000};

    // Reset with the button already held; it must be ignored until re-pressed.
    reset_count = 1'b1; db_in = 1'b1; clr_count = 1'b0;
    model_reset();
    #12;
    check("reset_state", 8'b0);
    @(negedge clk);
    reset_count = 1'b0;
    @(posedge clk); #1;
    model_edge(1'b1, 1'b0);
    for (int i = 0; i < 20; i++) mstep(1'b1, 1'b0);
    check("held_through_reset", 8'b0);

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].db, tbl[i].clr);
      check($sformatf("table[%0d]", i), tbl[i].exp);
    end

    // Minimum and threshold-length presses.
    mstep(1'b0, 1'b0);
    mstep(1'b1, 1'b0);
    check_bit("min_press_tick", press_tick, 1'b1);
    mstep(1'b0, 1'b0);
    check_bit("min_press_short", short_press, 1'b1);

    mstep(1'b1, 1'b0);
    for (int k = 1; k <= 7; k++) mstep(1'b1, 1'b0);
    mstep(1'b0, 1'b0);
    check_bit("release_at_threshold_short", short_press, 1'b1);
    check_bit("release_at_threshold_nolong", long_press, 1'b0);

    // Long hold with repeats.
    mstep(1'b0, 1'b0);
    c0 = m_cnt;
    mstep(1'b1, 1'b0);
    long_at = -1;
    for (int k = 1; k <= 30; k++) begin
      mstep(1'b1, 1'b0);
      if (long_press) long_at = k;
      if (repeat_tick) rep_q.push_back(k);
    end
    n_cmp++;
    if (long_at != L) begin
      n_bad++;
      $display("FAIL long_press_offset: got %0d required %0d", long_at, L);
    end
    n_cmp++;
    if (rep_q.size() != 5) begin
      n_bad++;
      $display("FAIL repeat_count: got %0d required 5", rep_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_cmp++;
        if (rep_q[i] != exp_rep[i]) begin
          n_bad++;
          $display("FAIL repeat_offset[%0d]: got %0d required %0d", i, rep_q[i], exp_rep[i]);
        end
      end
    end
    mstep(1'b0, 1'b0);
    check_bit("long_release_tick", release_tick, 1'b1);
    check_bit("long_release_noshort", short_press, 1'b0);
    n_cmp++;
    if (int'(press_count) != (c0 + 1) % (1 << CW)) begin
      n_bad++;
      $display("FAIL long_count: got %0d required %0d", press_count, (c0 + 1) % (1 << CW));
    end

    // Counter wrap, then clear colliding with an increment.
    mstep(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      mstep(1'b1, 1'b0);
      mstep(1'b0, 1'b0);
      n_cmp++;
      if (int'(press_count) != exp_wrap[i]) begin
        n_bad++;
        $display("FAIL wrap[%0d]: got %0d required %0d", i, press_count, exp_wrap[i]);
      end
    end
    mstep(1'b1, 1'b0);
    mstep(1'b0, 1'b1);
    check_bit("clr_beats_inc_short", short_press, 1'b1);
    n_cmp++;
    if (press_count != '0) begin
      n_bad++;
      $display("FAIL clr_beats_inc: got %0d required 0", press_count);
    end

    // Reset in the long-hold state with the button still down.
    mstep(1'b1, 1'b0);
    for (int k = 1; k <= 10; k++) mstep(1'b1, 1'b0);
    check_bit("in_long_held", held, 1'b1);
    #2;
    reset_count = 1'b1;
    #1;
    model_reset();
    check("reset_in_long", 8'b0);
    #2;
    reset_count = 1'b0;
    for (int i = 0; i < 5; i++) mstep(1'b1, 1'b0);
    check("no_press_after_reset", 8'b0);
    mstep(1'b0, 1'b0);
    mstep(1'b1, 1'b0);
    check_bit("repress_after_reset", press_tick, 1'b1);

    // Random runs of levels, occasional clears.
    run = 0; lvl = 0;
    for (int i = 0; i < 1500; i++) begin
      if (run == 0) begin
        lvl = ~lvl & 1;
        run = (lvl != 0) ? $urandom_range(1, 22) : $urandom_range(1, 4);
      end
      run--;
      mstep(lvl[0], ($urandom_range(0, 15) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/button_event_decoder.md
Name: button_event_decoder

Overview:
Consumes the clean, debounced button level produced by the debounce stage in the same clk domain. Converts that level into one-cycle event pulses: press, short press, long press, auto-repeat while held, and release. Maintains a wrapping press counter for display and control logic further downstream. All outputs are registered.

Parameters:
LONG_CYCLES, 50_000_000, hold time in clk cycles that separates a short press from a long press (0.5 s at 100 MHz); legal range >= 2
REPEAT_CYCLES, 20_000_000, period in clk cycles of repeat_tick while in long-hold; legal range >= 1
TIMER_W, 26, width of the hold timer; must satisfy 2^TIMER_W > max(LONG_CYCLES, REPEAT_CYCLES)
CNT_W, 8, width of press_count

Ports:
clk  in  1  system clock, 100 MHz
reset_count  in  1  asynchronous, active-high reset
db_in  in  1  debounced button level, synchronous to clk, 1 = pressed
clr_count  in  1  synchronous clear of press_count
press_tick  out  1  one-cycle pulse on detected press
short_press  out  1  one-cycle pulse when released before LONG_CYCLES
long_press  out  1  one-cycle pulse when hold reaches LONG_CYCLES
repeat_tick  out  1  one-cycle pulse every REPEAT_CYCLES while in long-hold
release_tick  out  1  one-cycle pulse on any release
held  out  1  level: 1 while state != IDLE
press_count  out  CNT_W  number of classified presses, modulo 2^CNT_W

Behaviour:
- Reset is asserted by reset_count and is asynchronous, active-high. Clock is clk.
- Values during reset: state = IDLE, hold_cnt = 0, db_d = 1, all pulse outputs = 0, held = 0, press_count = 0.
- db_d resets to 1, so a button already held through reset is ignored until it is released and pressed again.
- db_d: register of db_in, updated every cycle. A rise is db_in = 1 and db_d = 0 at a clk edge.
- Pulse outputs default to 0 every cycle. None is ever high for 2 consecutive cycles, except repeat_tick when REPEAT_CYCLES = 1.
- FSM states: IDLE, PRESSED, LONG.
- IDLE:
  - On a rise: go to PRESSED, hold_cnt <= 0, press_tick <= 1.
  - Otherwise remain in IDLE.
- PRESSED (evaluated at each edge):
  - If db_in = 0: go to IDLE, short_press <= 1, release_tick <= 1, press_count increments.
  - Else if hold_cnt == LONG_CYCLES-1: go to LONG, long_press <= 1, hold_cnt <= 0, press_count increments.
  - Else: hold_cnt <= hold_cnt + 1.
  - Release wins over the threshold when both apply in the same cycle, giving a short press.
- LONG:
  - If db_in = 0: go to IDLE, release_tick <= 1. No count change.
  - Else if hold_cnt == REPEAT_CYCLES-1: repeat_tick <= 1, hold_cnt <= 0.
  - Else: hold_cnt <= hold_cnt + 1.
- Timing:
  - press_tick is high in the cycle after the first edge that samples db_in = 1.
  - long_press is high exactly LONG_CYCLES cycles after press_tick.
  - The first repeat_tick is REPEAT_CYCLES cycles after long_press, then every REPEAT_CYCLES cycles after that.
  - The minimum press is db_in high for 1 sampled edge: press_tick in cycle n, short_press + release_tick in cycle n+1.
- press_count:
  - Increments by exactly 1 per press, at classification (short or long).
  - Wraps from 2^CNT_W-1 to 0 with no flag.
  - clr_count = 1 forces 0 at the next edge. It has priority over a simultaneous increment, and the result is 0.
- held is registered: 1 in the cycles where state is PRESSED or LONG.
- A new rise is only possible from IDLE. Since release always returns to IDLE with db_d = 0, back-to-back presses separated by 1 low cycle are each detected.
- Asserting reset_count mid-press aborts the press with no pulses and no count. Pressing again after reset requires a fresh rise.

Test Plan:
- LONG_CYCLES = 8, REPEAT_CYCLES = 4.
  - Reset with db_in = 1, release reset, hold db_in = 1 for 20 cycles -> no pulses, held = 0, press_count = 0. Then db_in = 0 for 2 cycles, then 1 -> press_tick one cycle later.
  - db_in high for 3 edges, then low -> press_tick, then short_press + release_tick 3 cycles later, press_count = 1, no long_press.
  - db_in high for 7 edges after press_tick's edge (release at hold_cnt == 7) -> short_press, not long_press. High for 8 or more -> long_press exactly 8 cycles after press_tick, press_count increments once.
  - Hold for 30 cycles past press_tick -> long_press at +8, repeat_tick at +12, +16, +20, +24, +28. On release: release_tick only, no short_press, count +1 total.
- CNT_W = 2: 5 short presses -> press_count sequence 1, 2, 3, 0, 1. clr_count pulsed on the same edge as the 6th press's increment -> press_count = 0.
- Assert reset_count while in LONG -> outputs immediately at reset values, press_count = 0. With db_in still 1 after reset release -> no press_tick until release and re-press.
